test_algo_2w: RTL and testbench
===============================

Name: test_algo_2w

Overview:
- Bit-packed circular FIFO. It stores 10-bit items back-to-back, with no padding, in a register file of eleven 32-bit words.
- An item may straddle two adjacent words, including the wrap from the last word to word 0.
- All storage words, the status and the read data are exposed as outputs so a bench or packer logic can observe the packing directly.

Parameters:
- ITEM_W, 10: item width in bits.
- WORD_W, 32: storage word width in bits.
- NUM_WORDS, 11: number of storage words. Total storage TOTAL = NUM_WORDS*WORD_W = 352 bits.
- Capacity CAP = floor(TOTAL/ITEM_W) = 35 items. Only the defaults are required to be verified.

Ports:
- CLOCK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- WRITE_IN  in  1  write strobe, sampled every cycle; high = one write.
- READ_IN  in  1  read strobe, sampled every cycle; high = one read.
- DATA_IN  in  10  item to write.
- STATE  out  2  status: 00 EMPTY, 01 PARTIAL, 10 FULL, 11 ERROR.
- DATA_0 .. DATA_10  out  32 each  storage words 0..10.
- DATA_OUT  out  10  last item read (registered).

Behaviour:
- Reset (RESET low, asynchronous): all storage words = 0, write pointer = 0, read pointer = 0, count = 0, DATA_OUT = 0, STATE = 00.
- Addressing: pointers are absolute bit positions 0..351.
  - Bit b lives in DATA_(b/32)[b%32].
  - Item bit k is stored at absolute bit (p+k) mod 352. Packing is LSB-first.
  - Pointers advance by 10 mod 352, so an item may span word n and word n+1, or word 10 and word 0.
- Write: if WRITE_IN=1 and the write is accepted:
  - the 10 target bits are updated at the clock edge; all other bits are unchanged;
  - the write pointer advances by 10.
- Read: if READ_IN=1 and the read is accepted:
  - DATA_OUT is loaded at that edge with the item at the read pointer, so it is valid the cycle after the strobe;
  - the read pointer advances by 10;
  - storage is not cleared.
- DATA_OUT holds its value when no read is accepted.
- Acceptance rules:
  - A write is accepted if count < 35, or if count = 35 and a read is accepted in the same cycle.
  - A read is accepted if count > 0. There is no write-to-read bypass: a read while count = 0 is rejected even if a write occurs in the same cycle.
  - Simultaneous accepted read and write leave count unchanged. The read returns the old item.
- Count update: +1 for an accepted write only, -1 for an accepted read only.
- STATE is registered and reflects the post-edge condition:
  - 11 (ERROR) if any strobe was rejected at that edge;
  - otherwise 00 if count = 0, 10 if count = 35, else 01.
  - ERROR lasts exactly one cycle unless rejections continue.
- Strobes held high for N cycles perform N operations. There is no edge detection.

Optional Feature:
- Macro: TEST_ALGO_DEBUG_EN.
- When defined, four extra outputs are added:
  - WRITE_BITS_LEFT [5:0] = 32 - (write pointer mod 32), range 1..32.
  - READ_BITS_LEFT [5:0] = 32 - (read pointer mod 32), range 1..32.
  - W_FLAG [1:0]: 01 if the last accepted write fit in one word, 10 if it straddled two words, 00 when no write was accepted that cycle. Registered; reset 0.
  - R_FLAG [1:0]: the same encoding for reads.
- Reset values: the bits-left outputs reset to 32 (6'd32); W_FLAG and R_FLAG reset to 0.
- When undefined, these ports and their logic are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset then idle -> all DATA_x = 0, DATA_OUT = 0, STATE = 00.
- Write 0x200, then read -> DATA_0 = 0x00000200; DATA_OUT = 0x200 the cycle after the read; STATE returns to 00.
- 11 write/read pairs with DATA_IN = 0x200 shifted right by 1 each pair:
  - each DATA_OUT equals the value written;
  - the 4th item (0x040 at bit 30) sets DATA_1[4] = 1;
  - STATE toggles 01/00.
- 35 writes -> STATE = 10. A 36th write -> STATE = 11 for one cycle with storage unchanged, then back to 10.
- Read on empty -> STATE = 11 and DATA_OUT unchanged. Read plus write while full -> both accepted, STATE stays 10.
- Wrap case: 35 writes and 35 reads, then write 0x3FF at pointer 350 -> DATA_10[31:30] = 2'b11 and DATA_0[7:0] = 0xFF. Reading that item back returns 0x3FF.
- Reset asserted mid-sequence -> everything cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/test_algo_2w.sv
// Bit-packed circular FIFO: 10-bit items stored back-to-back in eleven 32-bit words.
// Optional macro TEST_ALGO_DEBUG_EN adds pointer bits-left and straddle flag outputs.
module test_algo_2w #(
    parameter int ITEM_W    = 10,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 11
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              WRITE_IN,
    input  logic              READ_IN,
    input  logic [ITEM_W-1:0] DATA_IN,
    output logic [1:0]        STATE,
    output logic [WORD_W-1:0] DATA_0,
    output logic [WORD_W-1:0] DATA_1,
    output logic [WORD_W-1:0] DATA_2,
    output logic [WORD_W-1:0] DATA_3,
    output logic [WORD_W-1:0] DATA_4,
    output logic [WORD_W-1:0] DATA_5,
    output logic [WORD_W-1:0] DATA_6,
    output logic [WORD_W-1:0] DATA_7,
    output logic [WORD_W-1:0] DATA_8,
    output logic [WORD_W-1:0] DATA_9,
    output logic [WORD_W-1:0] DATA_10,
`ifdef TEST_ALGO_DEBUG_EN
    output logic [5:0]        WRITE_BITS_LEFT,
    output logic [5:0]        READ_BITS_LEFT,
    output logic [1:0]        W_FLAG,
    output logic [1:0]        R_FLAG,
`endif
    output logic [ITEM_W-1:0] DATA_OUT
);
    localparam int TOTAL = NUM_WORDS * WORD_W;
    localparam int CAP   = TOTAL / ITEM_W;
    localparam int PTR_W = $clog2(TOTAL);
    localparam int CNT_W = $clog2(CAP + 1);

    localparam logic [1:0] ST_EMPTY   = 2'b00;
    localparam logic [1:0] ST_PARTIAL = 2'b01;
    localparam logic [1:0] ST_FULL    = 2'b10;
    localparam logic [1:0] ST_ERROR   = 2'b11;

    logic [TOTAL-1:0]  mem;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [ITEM_W-1:0] rd_item;
    logic              rd_acc;
    logic              wr_acc;
    logic              reject;

    // Absolute bit position p+k folded back into the circular bit space.
    function automatic logic [PTR_W-1:0] bit_idx(input logic [PTR_W-1:0] p, input int k);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(k);
        if (s >= (PTR_W+1)'(TOTAL))
            s = s - (PTR_W+1)'(TOTAL);
        return s[PTR_W-1:0];
    endfunction

    assign rd_acc = READ_IN && (count != '0);
    assign wr_acc = WRITE_IN && ((count < CNT_W'(CAP)) || rd_acc);
    assign reject = (WRITE_IN && !wr_acc) || (READ_IN && !rd_acc);

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + 1'b1;
        else if (rd_acc && !wr_acc)
            count_nxt = count - 1'b1;
    end

    always_comb begin
        rd_item = '0;
        for (int k = 0; k < ITEM_W; k++)
            rd_item[k] = mem[bit_idx(rd_ptr, k)];
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            DATA_OUT <= '0;
            STATE    <= ST_EMPTY;
        end else begin
            if (wr_acc) begin
                for (int k = 0; k < ITEM_W; k++)
                    mem[bit_idx(wr_ptr, k)] <= DATA_IN[k];
                wr_ptr <= bit_idx(wr_ptr, ITEM_W);
            end
            if (rd_acc) begin
                DATA_OUT <= rd_item;
                rd_ptr   <= bit_idx(rd_ptr, ITEM_W);
            end
            count <= count_nxt;
            if (reject)
                STATE <= ST_ERROR;
            else if (count_nxt == '0)
                STATE <= ST_EMPTY;
            else if (count_nxt == CNT_W'(CAP))
                STATE <= ST_FULL;
            else
                STATE <= ST_PARTIAL;
        end
    end

    assign DATA_0  = mem[0*WORD_W  +: WORD_W];
    assign DATA_1  = mem[1*WORD_W  +: WORD_W];
    assign DATA_2  = mem[2*WORD_W  +: WORD_W];
    assign DATA_3  = mem[3*WORD_W  +: WORD_W];
    assign DATA_4  = mem[4*WORD_W  +: WORD_W];
    assign DATA_5  = mem[5*WORD_W  +: WORD_W];
    assign DATA_6  = mem[6*WORD_W  +: WORD_W];
    assign DATA_7  = mem[7*WORD_W  +: WORD_W];
    assign DATA_8  = mem[8*WORD_W  +: WORD_W];
    assign DATA_9  = mem[9*WORD_W  +: WORD_W];
    assign DATA_10 = mem[10*WORD_W +: WORD_W];

`ifdef TEST_ALGO_DEBUG_EN
    localparam int OFF_W = $clog2(WORD_W);

    logic [OFF_W-1:0] wr_off;
    logic [OFF_W-1:0] rd_off;

    // TOTAL is a multiple of WORD_W, so the low pointer bits are the in-word offset.
    assign wr_off = wr_ptr[OFF_W-1:0];
    assign rd_off = rd_ptr[OFF_W-1:0];
    assign WRITE_BITS_LEFT = 6'(WORD_W) - 6'(wr_off);
    assign READ_BITS_LEFT  = 6'(WORD_W) - 6'(rd_off);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            W_FLAG <= 2'b00;
            R_FLAG <= 2'b00;
        end else begin
            W_FLAG <= !wr_acc ? 2'b00 : ((6'(wr_off) + 6'(ITEM_W) > 6'(WORD_W)) ? 2'b10 : 2'b01);
            R_FLAG <= !rd_acc ? 2'b00 : ((6'(rd_off) + 6'(ITEM_W) > 6'(WORD_W)) ? 2'b10 : 2'b01);
        end
    end
`endif

endmodule

// File: tb/tb_test_algo_2w.sv
// Bench for test_algo_2w: bit-level FIFO model compared every cycle, plus literal checkpoints.
module tb_test_algo_2w;
    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        WRITE_IN = 1'b0;
    logic        READ_IN = 1'b0;
    logic [9:0]  DATA_IN = '0;
    logic [1:0]  STATE;
    logic [31:0] DATA_0, DATA_1, DATA_2, DATA_3, DATA_4, DATA_5;
    logic [31:0] DATA_6, DATA_7, DATA_8, DATA_9, DATA_10;
    logic [9:0]  DATA_OUT;
    logic [31:0] dw [11];

    int n_checks = 0;
    int n_errors = 0;

    test_algo_2w dut (
        .CLOCK(CLOCK), .RESET(RESET), .WRITE_IN(WRITE_IN), .READ_IN(READ_IN),
        .DATA_IN(DATA_IN), .STATE(STATE),
        .DATA_0(DATA_0), .DATA_1(DATA_1), .DATA_2(DATA_2), .DATA_3(DATA_3),
        .DATA_4(DATA_4), .DATA_5(DATA_5), .DATA_6(DATA_6), .DATA_7(DATA_7),
        .DATA_8(DATA_8), .DATA_9(DATA_9), .DATA_10(DATA_10),
        .DATA_OUT(DATA_OUT)
    );

    assign dw[0] = DATA_0;  assign dw[1] = DATA_1;  assign dw[2]  = DATA_2;
    assign dw[3] = DATA_3;  assign dw[4] = DATA_4;  assign dw[5]  = DATA_5;
    assign dw[6] = DATA_6;  assign dw[7] = DATA_7;  assign dw[8]  = DATA_8;
    assign dw[9] = DATA_9;  assign dw[10] = DATA_10;

    always #5 CLOCK = ~CLOCK;

    // Reference model: flat bit array, integer pointers and count.
    bit       m_bits [352];
    int       m_wp, m_rp, m_cnt;
    int       m_dout, m_state;

    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            foreach (m_bits[i]) m_bits[i] = 1'b0;
            m_wp = 0; m_rp = 0; m_cnt = 0; m_dout = 0; m_state = 0;
        end else begin
            bit rd_ok, wr_ok;
            rd_ok = READ_IN && m_cnt > 0;
            wr_ok = WRITE_IN && (m_cnt < 35 || rd_ok);
            if (rd_ok) begin
                m_dout = 0;
                for (int k = 0; k < 10; k++)
                    if (m_bits[(m_rp + k) % 352]) m_dout += (1 << k);
                m_rp = (m_rp + 10) % 352;
            end
            if (wr_ok) begin
                for (int k = 0; k < 10; k++)
                    m_bits[(m_wp + k) % 352] = DATA_IN[k];
                m_wp = (m_wp + 10) % 352;
            end
            m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
            if ((WRITE_IN && !wr_ok) || (READ_IN && !rd_ok)) m_state = 3;
            else if (m_cnt == 0) m_state = 0;
            else if (m_cnt == 35) m_state = 2;
            else m_state = 1;
        end
    end

    function automatic logic [31:0] m_word(input int n);
        logic [31:0] w;
        for (int b = 0; b < 32; b++) w[b] = m_bits[n*32 + b];
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK) begin
        chk("model STATE", 32'(STATE), 32'(m_state));
        chk("model DATA_OUT", 32'(DATA_OUT), 32'(m_dout));
        for (int n = 0; n < 11; n++)
            chk($sformatf("model DATA_%0d", n), dw[n], m_word(n));
    end

    task automatic cyc(input logic w, input logic r, input logic [9:0] d);
        WRITE_IN = w; READ_IN = r; DATA_IN = d;
        @(posedge CLOCK); #1;
        WRITE_IN = 1'b0; READ_IN = 1'b0; DATA_IN = '0;
    endtask

    initial begin
        logic [9:0] d;
        #23 RESET = 1'b1;
        @(posedge CLOCK); #1;
        cyc(0, 0, 0);
        chk("reset STATE", 32'(STATE), 32'h0);
        chk("reset DATA_OUT", 32'(DATA_OUT), 32'h0);
        chk("reset DATA_0", DATA_0, 32'h0);

        cyc(1, 0, 10'h200);
        chk("first write DATA_0", DATA_0, 32'h0000_0200);
        chk("first write STATE", 32'(STATE), 32'h1);
        cyc(0, 1, 0);
        chk("first read DATA_OUT", 32'(DATA_OUT), 32'h200);
        chk("first read STATE", 32'(STATE), 32'h0);

        for (int i = 0; i < 11; i++) begin
            d = 10'h200 >> (i + 1);
            cyc(1, 0, d);
            chk("pair write STATE", 32'(STATE), 32'h1);
            if (i == 2) chk("item 0x040 DATA_1[4]", 32'(DATA_1[4]), 32'h1);
            cyc(0, 1, 0);
            chk("pair read DATA_OUT", 32'(DATA_OUT), 32'(d));
            chk("pair read STATE", 32'(STATE), 32'h0);
        end

        for (int i = 0; i < 35; i++) cyc(1, 0, 10'((i * 7 + 1) & 10'h3FF));
        chk("35 writes STATE", 32'(STATE), 32'h2);
        cyc(1, 0, 10'h155);
        chk("overflow STATE", 32'(STATE), 32'h3);
        cyc(0, 0, 0);
        chk("after overflow STATE", 32'(STATE), 32'h2);
        cyc(1, 1, 10'h2AA);
        chk("rw full STATE", 32'(STATE), 32'h2);
        chk("rw full DATA_OUT", 32'(DATA_OUT), 32'h001);

        for (int i = 0; i < 35; i++) cyc(0, 1, 0);
        chk("drained STATE", 32'(STATE), 32'h0);
        chk("drained DATA_OUT", 32'(DATA_OUT), 32'h2AA);
        cyc(0, 1, 0);
        chk("read empty STATE", 32'(STATE), 32'h3);
        chk("read empty DATA_OUT", 32'(DATA_OUT), 32'h2AA);
        cyc(1, 1, 10'h0AB);
        chk("rw empty STATE", 32'(STATE), 32'h3);
        chk("rw empty DATA_OUT", 32'(DATA_OUT), 32'h2AA);
        cyc(0, 1, 0);
        chk("rw empty readback", 32'(DATA_OUT), 32'h0AB);
        chk("rw empty readback STATE", 32'(STATE), 32'h0);

        for (int i = 0; i < 3; i++) cyc(1, 0, 10'h3C3);
        cyc(0, 1, 0);
        #2 RESET = 1'b0;
        #1;
        chk("async reset DATA_0", DATA_0, 32'h0);
        chk("async reset DATA_4", DATA_4, 32'h0);
        chk("async reset STATE", 32'(STATE), 32'h0);
        chk("async reset DATA_OUT", 32'(DATA_OUT), 32'h0);
        @(posedge CLOCK); #3 RESET = 1'b1;
        @(posedge CLOCK); #1;

        for (int i = 0; i < 35; i++) cyc(1, 0, 10'(i + 16));
        for (int i = 0; i < 35; i++) cyc(0, 1, 0);
        cyc(1, 0, 10'h3FF);
        chk("wrap DATA_10[31:30]", 32'(DATA_10[31:30]), 32'h3);
        chk("wrap DATA_0[7:0]", 32'(DATA_0[7:0]), 32'hFF);
        cyc(0, 1, 0);
        chk("wrap readback", 32'(DATA_OUT), 32'h3FF);
        chk("wrap readback STATE", 32'(STATE), 32'h0);
        cyc(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
